// File: rtl/alu_pkg.sv
// Shared ALU opcode and state types.
// The opcode encoding matches the ALU control decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAnd = 4'b0000,
        AluOr  = 4'b0001,
        AluAdd = 4'b0010,
        AluSll = 4'b0011,
        AluSrl = 4'b0100,
        AluSra = 4'b0101,
        AluSub = 4'b0110,
        AluSlt = 4'b0111,
        AluNor = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY
    } alu_state_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == AluSll) || (op == AluSrl) || (op == AluSra);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle for the execute-stage ALU.
// The slave side is the ALU; the master side is the operand mux and the writeback consumer.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      control_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            illegal_o;

    modport master (
        output in_valid, control_i, a_i, b_i, out_ready,
        input  in_ready, out_valid, result_o, zero_o, illegal_o
    );

    modport slave (
        input  in_valid, control_i, a_i, b_i, out_ready,
        output in_ready, out_valid, result_o, zero_o, illegal_o
    );

endinterface

// File: rtl/alu_shift_iter.sv
// Iterative shifter: one bit per cycle, with a down-counter for the remaining shift amount.
// done_o is high during the final step; result_o then holds the fully shifted value.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            start_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] value_i,
    input  logic [SHW-1:0]  shamt_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] val_q;
    logic [SHW-1:0]  cnt_q;
    alu_op_e         op_q;
    logic            busy_q;

    // result_o is the value after one more step; it feeds both the register and the output.
    always_comb begin
        case (op_q)
            AluSll:  result_o = {val_q[XLEN-2:0], 1'b0};
            AluSra:  result_o = {val_q[XLEN-1], val_q[XLEN-1:1]};
            default: result_o = {1'b0, val_q[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= '0;
            cnt_q  <= '0;
            op_q   <= AluSrl;
            busy_q <= 1'b0;
        end else if (clr_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            val_q  <= value_i;
            cnt_q  <= shamt_i;
            op_q   <= op_i;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            val_q <= result_o;
            cnt_q <= cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == SHW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts, registered result.
// Valid/ready on both sides; flush_i aborts any in-flight op and drops a pending result.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush_i,
    alu_exec_unit_if.slave io
);

    alu_state_e      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    alu_op_e         op;
    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            long_shift;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            sh_busy;
    logic            sh_done;
    logic [XLEN-1:0] sh_result;

    assign op         = alu_op_e'(io.control_i);
    assign shamt      = io.b_i[SHW-1:0];
    assign long_shift = is_shift(op) && (shamt != '0);
    // rst_n gates ready so nothing is accepted while the unit is held in reset.
    assign io.in_ready = rst_n && (state_q == IDLE) && !sh_busy
                         && (!out_valid_q || io.out_ready) && !flush_i;
    assign accept     = io.in_valid && io.in_ready;

    alu_shift_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (flush_i),
        .start_i  (accept && long_shift),
        .op_i     (op),
        .value_i  (io.a_i),
        .shamt_i  (shamt),
        .busy_o   (sh_busy),
        .done_o   (sh_done),
        .result_o (sh_result)
    );

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (io.control_i)
            AluAnd: alu_res = io.a_i & io.b_i;
            AluOr:  alu_res = io.a_i | io.b_i;
            AluAdd: alu_res = io.a_i + io.b_i;
            AluSub: alu_res = io.a_i - io.b_i;
            AluSlt: alu_res = {{(XLEN-1){1'b0}}, $signed(io.a_i) < $signed(io.b_i)};
            AluNor: alu_res = ~(io.a_i | io.b_i);
            AluSll, AluSrl, AluSra: alu_res = io.a_i;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        if (flush_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else if (state_q == BUSY) begin
            if (sh_done) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                result_d    = sh_result;
                zero_d      = (sh_result == '0);
                illegal_d   = 1'b0;
            end
        end else if (accept) begin
            if (long_shift) begin
                state_d     = BUSY;
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                illegal_d   = alu_ill;
            end
        end else if (out_valid_q && io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.result_o  = result_q;
    assign io.zero_o    = zero_q;
    assign io.illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed handshake/flush/reset cases plus a random mix.
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_i;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(
        .XLEN (32),
        .SHW  (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .io      (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        int          acc;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  seen    = 1'b0;
    bit  bp_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic sb_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
        sb_t e;
        int  sh;
        sh    = int'(b[4:0]);
        e.ill = 1'b0;
        e.lat = 1;
        e.acc = 0;
        e.res = '0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: e.res = ~(a | b);
            4'b0011: e.res = a << sh;
            4'b0100: e.res = a >> sh;
            4'b0101: e.res = $signed(a) >>> sh;
            default: e.ill = 1'b1;
        endcase
        if ((op == 4'b0011 || op == 4'b0100 || op == 4'b0101) && sh != 0) e.lat = sh + 1;
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Call just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
        sb_t e;
        int  n;
        bus.in_valid  = 1'b1;
        bus.control_i = op;
        bus.a_i       = a;
        bus.b_i       = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (push) begin
                    e     = model(op, a, b);
                    e.acc = cyc;
                    sb_q.push_back(e);
                end
                break;
            end
            n++;
            if (n > 200) begin
                check_eq("accept_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    check_eq("result", bus.result_o, sb_q[0].res);
                    check_eq("zero", 32'(bus.zero_o), 32'(sb_q[0].zero));
                    check_eq("illegal", 32'(bus.illegal_o), 32'(sb_q[0].ill));
                    check_eq("latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
                    seen = 1'b1;
                end
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failed %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [10];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                4'b0011, 4'b0100, 4'b0101, 4'b1000};
        rst_n         = 1'b0;
        flush_i       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.control_i = '0;
        bus.a_i       = '0;
        bus.b_i       = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_result", bus.result_o, 32'd0);
        check_eq("rst_zero", 32'(bus.zero_o), 32'd0);
        check_eq("rst_illegal", 32'(bus.illegal_o), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(4'b0010, 32'd7, 32'd5, 1'b1);
        send(4'b0110, 32'd9, 32'd9, 1'b1);
        send(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1);

        send(4'b0101, 32'h8000_0000, 32'd4, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check_eq("sra_busy_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        check_eq("sra_done_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        send(4'b0011, 32'hA5A5_0001, 32'd0, 1'b1);

        // Backpressure: hold an ADD result, then retire it while accepting an OR.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(4'b0010, 32'd3, 32'd4, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check_eq("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_result", bus.result_o, 32'd7);
            check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(4'b0001, 32'h0000_00F0, 32'h0000_000F, 1'b1);
        @(negedge clk);
        check_eq("no_bubble_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

        send(4'b1111, 32'h1234_5678, 32'h0000_5678, 1'b1);

        // Flush during a long SRL: the result must never appear.
        send(4'b0100, 32'hFFFF_0000, 32'd20, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check_eq("flush_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check_eq("post_flush_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (25) begin
            @(negedge clk);
            check_eq("post_flush_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of a long SRA.
        send(4'b0101, 32'h8765_4321, 32'd10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midbusy_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midbusy_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("midbusy_rst_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'b0010, 32'd1, 32'd1, 1'b1);

        bp_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send(ops[$urandom_range(0, 9)], $urandom, $urandom, 1'b1);
        end
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
